// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants, the saturated Tnew decrement and the priority-resolved
// action encoding used by the pipeline stage register.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_PC     = 32'h0000_4180;
    localparam int          TNEW_W_DEFAULT   = 3;
    localparam logic [31:0] PERF_CNT_MAX     = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_LOAD
    } stage_action_e;

    // Callers zero-extend Tnew into 32 bits and truncate the result back;
    // the result never exceeds the input, so truncation is lossless.
    function automatic logic [31:0] tnew_dec(input logic [31:0] tnew);
        logic [31:0] result;
        if (tnew == 32'd0) begin
            result = 32'd0;
        end else begin
            result = tnew - 32'd1;
        end
        return result;
    endfunction

    function automatic stage_action_e resolve_action(
        input logic reset,
        input logic flush,
        input logic stall,
        input logic bubble
    );
        stage_action_e act;
        if (reset) begin
            act = ACT_RESET;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else if (stall) begin
            act = ACT_HOLD;
        end else if (bubble) begin
            act = ACT_BUBBLE;
        end else begin
            act = ACT_LOAD;
        end
        return act;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_perf_cnt.sv
// Saturating 32-bit event counter with synchronous reset and clear.
module pipe_perf_cnt
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    logic [31:0] r_count;

    // Clear beats increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 32'd0;
        end else if (clr) begin
            r_count <= 32'd0;
        end else if (inc && (r_count != PERF_CNT_MAX)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Configurable pipeline stage register (valid/pc/bd/Tnew/payload) with
// hold, pc-preserving bubble and flush. PIPE_STAGE_PERF_EN adds stall/bubble counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          WIDTH            = 64,
    parameter int          TNEW_W           = TNEW_W_DEFAULT,
    parameter int          DEC_TNEW         = 1,
    parameter int          CLEAR_ON_INVALID = 1,
    parameter logic [31:0] RESET_PC         = RESET_PC_DEFAULT,
    parameter logic [31:0] FLUSH_PC         = EXC_ENTRY_PC
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              bubble,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic              out_bd,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [WIDTH-1:0]  out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_hold_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    stage_action_e     w_action;
    logic [TNEW_W-1:0] w_tnew_dec;
    logic [TNEW_W-1:0] w_load_tnew;
    logic [WIDTH-1:0]  w_load_data;

    logic              r_valid;
    logic [31:0]       r_pc;
    logic              r_bd;
    logic [TNEW_W-1:0] r_tnew;
    logic [WIDTH-1:0]  r_data;

    // An invalid entry never carries a pending Tnew, whatever the decrement mode.
    always_comb begin
        w_action    = resolve_action(reset, flush, stall, bubble);
        w_tnew_dec  = TNEW_W'(tnew_dec(32'(in_tnew)));
        w_load_tnew = '0;
        if (in_valid) begin
            w_load_tnew = (DEC_TNEW != 0) ? w_tnew_dec : in_tnew;
        end
        w_load_data = in_data;
        if ((CLEAR_ON_INVALID != 0) && !in_valid) begin
            w_load_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_bd    <= 1'b0;
            r_tnew  <= '0;
            r_data  <= '0;
        end else begin
            case (w_action)
                ACT_FLUSH: begin
                    r_valid <= 1'b0;
                    r_pc    <= FLUSH_PC;
                    r_bd    <= 1'b0;
                    r_tnew  <= '0;
                    r_data  <= '0;
                end
                ACT_HOLD: begin
                    r_valid <= r_valid;
                    r_pc    <= r_pc;
                    r_bd    <= r_bd;
                    r_tnew  <= r_tnew;
                    r_data  <= r_data;
                end
                // Bubble keeps the stalled instruction's pc/bd visible for EPC.
                ACT_BUBBLE: begin
                    r_valid <= 1'b0;
                    r_pc    <= in_pc;
                    r_bd    <= in_bd;
                    r_tnew  <= '0;
                    r_data  <= '0;
                end
                default: begin
                    r_valid <= in_valid;
                    r_pc    <= in_pc;
                    r_bd    <= in_bd;
                    r_tnew  <= w_load_tnew;
                    r_data  <= w_load_data;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_pc    = r_pc;
    assign out_bd    = r_bd;
    assign out_tnew  = r_tnew;
    assign out_data  = r_data;

`ifdef PIPE_STAGE_PERF_EN
    logic w_hold_applied;
    logic w_bubble_applied;
    logic w_flush_applied;

    assign w_hold_applied   = (w_action == ACT_HOLD);
    assign w_bubble_applied = (w_action == ACT_BUBBLE);
    assign w_flush_applied  = (w_action == ACT_FLUSH);

    pipe_perf_cnt u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_hold_applied),
        .clr   (w_flush_applied),
        .count (perf_hold_cnt)
    );

    pipe_perf_cnt u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_bubble_applied),
        .clr   (w_flush_applied),
        .count (perf_bubble_cnt)
    );
`else
    // No counters in this build; the stage behaves identically.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: a default-configured
// instance plus one with DEC_TNEW=0 and CLEAR_ON_INVALID=0 sharing the same inputs.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic        in_bd;
    logic [2:0]  in_tnew;
    logic [63:0] in_data;

    logic        a_valid, b_valid;
    logic [31:0] a_pc, b_pc;
    logic        a_bd, b_bd;
    logic [2:0]  a_tnew, b_tnew;
    logic [63:0] a_data, b_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] a_hold, a_bub, b_hold, b_bub;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(
        .WIDTH(64), .TNEW_W(3), .DEC_TNEW(1), .CLEAR_ON_INVALID(1),
        .RESET_PC(32'h0000_3000), .FLUSH_PC(32'h0000_4180)
    ) dutA (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(a_valid), .out_pc(a_pc), .out_bd(a_bd), .out_tnew(a_tnew), .out_data(a_data)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_hold_cnt(a_hold), .perf_bubble_cnt(a_bub)
`endif
    );

    pipe_stage_reg #(
        .WIDTH(64), .TNEW_W(3), .DEC_TNEW(0), .CLEAR_ON_INVALID(0),
        .RESET_PC(32'h0000_3000), .FLUSH_PC(32'h0000_4180)
    ) dutB (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(b_valid), .out_pc(b_pc), .out_bd(b_bd), .out_tnew(b_tnew), .out_data(b_data)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_hold_cnt(b_hold), .perf_bubble_cnt(b_bub)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then samples 1 time unit after the edge.
    task automatic applyStimulus(
        input logic rst, input logic stl, input logic bub, input logic fl,
        input logic v, input logic [31:0] pc, input logic bd,
        input logic [2:0] tn, input logic [63:0] d
    );
        reset = rst; stall = stl; bubble = bub; flush = fl;
        in_valid = v; in_pc = pc; in_bd = bd; in_tnew = tn; in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkStageA(input string tag, input logic v, input logic [31:0] pc,
                               input logic bd, input logic [2:0] tn, input logic [63:0] d);
        checkOutput({tag, ".valid"}, 64'(a_valid), 64'(v));
        checkOutput({tag, ".pc"},    64'(a_pc),    64'(pc));
        checkOutput({tag, ".bd"},    64'(a_bd),    64'(bd));
        checkOutput({tag, ".tnew"},  64'(a_tnew),  64'(tn));
        checkOutput({tag, ".data"},  a_data,       d);
    endtask

    initial begin
        $display("[TB] starting pipe_stage_reg directed test");
        reset = 1'b1; stall = 1'b0; bubble = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_bd = 1'b0; in_tnew = '0; in_data = '0;
        #2;

        // Reset for two cycles with random upstream values
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $urandom, 1'b1,
                          3'($urandom_range(0, 7)), {$urandom, $urandom});
            checkStageA("reset", 1'b0, 32'h0000_3000, 1'b0, 3'd0, 64'd0);
            checkOutput("resetB.pc", 64'(b_pc), 64'h3000);
        end
`ifdef PIPE_STAGE_PERF_EN
        checkOutput("reset.hold", 64'(a_hold), 64'd0);
        checkOutput("reset.bub",  64'(a_bub),  64'd0);
`endif

        // First load after release, Tnew 2 decrements to 1 in A only
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3004, 1'b0, 3'd2, 64'hA5);
        checkStageA("load1", 1'b1, 32'h0000_3004, 1'b0, 3'd1, 64'hA5);
        checkOutput("load1B.tnew", 64'(b_tnew), 64'd2);

        // Tnew 0 saturates instead of wrapping to 7
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3008, 1'b0, 3'd0, 64'h5A);
        checkOutput("tnew0A", 64'(a_tnew), 64'd0);
        checkOutput("tnew0B", 64'(b_tnew), 64'd0);

        // Tnew at all-ones
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_300C, 1'b0, 3'd7, 64'h77);
        checkOutput("tnew7A", 64'(a_tnew), 64'd6);
        checkOutput("tnew7B", 64'(b_tnew), 64'd7);

        // Load the entry that will be held
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3010, 1'b0, 3'd3, 64'hDEAD_BEEF);
        checkStageA("preStall", 1'b1, 32'h0000_3010, 1'b0, 3'd2, 64'hDEAD_BEEF);

        // Three stall cycles with changing inputs leave everything untouched
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'(i), 32'h0000_3100 + 32'(i), 1'b1,
                          3'd5, {$urandom, $urandom});
            checkStageA("stall", 1'b1, 32'h0000_3010, 1'b0, 3'd2, 64'hDEAD_BEEF);
            checkOutput("stallB.tnew", 64'(b_tnew), 64'd3);
        end
`ifdef PIPE_STAGE_PERF_EN
        checkOutput("stall.hold", 64'(a_hold), 64'd3);
        checkOutput("stall.bub",  64'(a_bub),  64'd0);
`endif

        // Bubble keeps pc/bd, clears the rest
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3020, 1'b1, 3'd4, 64'h1234);
        checkStageA("bubble", 1'b0, 32'h0000_3020, 1'b1, 3'd0, 64'd0);
        checkOutput("bubbleB.data", b_data, 64'd0);

        // Stall and bubble together: hold wins
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3030, 1'b0, 3'd4, 64'h9999);
        checkStageA("stallBubble", 1'b0, 32'h0000_3020, 1'b1, 3'd0, 64'd0);
`ifdef PIPE_STAGE_PERF_EN
        checkOutput("stallBubble.hold", 64'(a_hold), 64'd4);
        checkOutput("stallBubble.bub",  64'(a_bub),  64'd1);
`endif

        // Flush beats stall and bubble, clears the counters
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3034, 1'b1, 3'd4, 64'h4444);
        checkStageA("flush", 1'b0, 32'h0000_4180, 1'b0, 3'd0, 64'd0);
        checkOutput("flushB.pc", 64'(b_pc), 64'h4180);
`ifdef PIPE_STAGE_PERF_EN
        checkOutput("flush.hold", 64'(a_hold), 64'd0);
        checkOutput("flush.bub",  64'(a_bub),  64'd0);
`endif

        // Invalid load: A clears payload, B keeps it, both drop Tnew
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3040, 1'b1, 3'd3, 64'hFFFF);
        checkStageA("invalid", 1'b0, 32'h0000_3040, 1'b1, 3'd0, 64'd0);
        checkOutput("invalidB.data", b_data, 64'hFFFF);
        checkOutput("invalidB.tnew", 64'(b_tnew), 64'd0);
        checkOutput("invalidB.valid", 64'(b_valid), 64'd0);
        checkOutput("invalidB.bd", 64'(b_bd), 64'd1);

        // Reset asserted during a stall, then a normal load afterwards
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3050, 1'b0, 3'd1, 64'hCAFE);
        checkStageA("preReset", 1'b1, 32'h0000_3050, 1'b0, 3'd0, 64'hCAFE);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3054, 1'b1, 3'd1, 64'hBEEF);
        checkStageA("resetStall", 1'b0, 32'h0000_3000, 1'b0, 3'd0, 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3060, 1'b1, 3'd2, 64'h60);
        checkStageA("postReset", 1'b1, 32'h0000_3060, 1'b1, 3'd1, 64'h60);
        checkOutput("postResetB.tnew", 64'(b_tnew), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the 5-stage MIPS core. It replaces the per-stage hand-written D/E/M/W registers with one configurable block. It carries an opaque payload plus dedicated valid, pc, branch-delay (bd) and Tnew fields. It supports hold (stall), bubble insertion that preserves pc/bd, exception/eret flush, and optional Tnew decrement.

Parameters:
WIDTH, 64, payload width in bits (control + data fields packed by the instantiating stage).
TNEW_W, 3, width of the Tnew field.
DEC_TNEW, 1, 1 = stored Tnew is the input Tnew decremented and saturated at 0; 0 = stored as-is.
CLEAR_ON_INVALID, 1, 1 = payload forced to 0 when a load has in_valid=0.
RESET_PC, 32'h0000_3000, pc value after reset.
FLUSH_PC, 32'h0000_4180, pc value loaded on flush (exception handler entry).

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
stall  input  1  hold current contents
bubble  input  1  insert bubble (upstream stage stalled)
flush  input  1  exception/eret flush
in_valid  input  1  upstream entry valid
in_pc  input  32  upstream pc
in_bd  input  1  upstream in-delay-slot flag
in_tnew  input  TNEW_W  upstream Tnew
in_data  input  WIDTH  upstream payload
out_valid  output  1  stored entry valid
out_pc  output  32  stored pc
out_bd  output  1  stored delay-slot flag
out_tnew  output  TNEW_W  stored Tnew
out_data  output  WIDTH  stored payload

Behaviour:
- All outputs are registers; latency is 1 cycle from inputs to outputs. There are no combinational paths from inputs to outputs.
- Reset (synchronous, active-high, highest priority): out_valid=0, out_pc=RESET_PC, out_bd=0, out_tnew=0, out_data=0.
- Per-cycle priority: reset > flush > stall > bubble > load.
- flush: out_valid=0, out_pc=FLUSH_PC, out_bd=0, out_tnew=0, out_data=0. Flush overrides a simultaneous stall.
- stall (without flush): all outputs hold their values. Tnew is not decremented while held.
- bubble (without stall/flush): out_valid=0, out_tnew=0, out_data=0. out_pc<=in_pc and out_bd<=in_bd, so the macroscopic pc/bd of the stalled instruction stays visible for EPC. If stall and bubble are both asserted, stall wins.
- load: out_valid<=in_valid, out_pc<=in_pc, out_bd<=in_bd.
  - out_data<=in_data, or 0 if CLEAR_ON_INVALID=1 and in_valid=0.
  - out_tnew<=(DEC_TNEW ? (in_tnew==0 ? 0 : in_tnew-1) : in_tnew).
  - If in_valid=0, out_tnew=0 regardless of DEC_TNEW.
- Tnew arithmetic: unsigned, TNEW_W bits. Decrement saturates at 0 and never wraps to all-ones.
- Reset asserted mid-stall: the reset values apply in that cycle. On the first cycle after deassertion with no control inputs asserted, the stage loads normally.
- Width rules: WIDTH>=1 and TNEW_W>=1. pc is always 32 bits.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs perf_hold_cnt[31:0] and perf_bubble_cnt[31:0].
  - Both reset to 0, and both clear on flush.
  - perf_hold_cnt increments on each cycle where stall is applied; perf_bubble_cnt increments on each cycle where bubble is applied. "Applied" follows the priority order above.
  - Both saturate at 32'hFFFF_FFFF.
- Not defined: ports and counters are absent. Core behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - RESET_PC_DEFAULT (32'h0000_3000) and EXC_ENTRY_PC (32'h0000_4180);
  - TNEW_W_DEFAULT = 3;
  - a function tnew_dec(tnew) implementing saturated decrement;
  - a localparam enum for the priority-resolved action: ACT_RESET, ACT_FLUSH, ACT_HOLD, ACT_BUBBLE, ACT_LOAD.
- One sub-module, pipe_perf_cnt: a saturating 32-bit counter with inc and clr inputs. It is instantiated twice, only under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset: reset=1 for 2 cycles with in_* random -> out_valid=0, out_pc=32'h0000_3000, out_tnew=0, out_data=0; first load after release passes in_pc=32'h0000_3004.
- Load + Tnew: in_valid=1, in_tnew=2, DEC_TNEW=1 -> next cycle out_tnew=1; then in_tnew=0 -> out_tnew=0 (no wrap to 7); DEC_TNEW=0 with in_tnew=2 -> out_tnew=2.
- Stall hold: load pc=32'h0000_3010, data=64'hDEAD_BEEF; assert stall 3 cycles with changing inputs -> outputs unchanged all 3 cycles; perf_hold_cnt=3 (macro on).
- Bubble: bubble=1, in_pc=32'h0000_3020, in_bd=1, in_data=64'h1234 -> out_valid=0, out_data=0, out_tnew=0, out_pc=32'h0000_3020, out_bd=1; with stall+bubble both high -> hold wins.
- Flush priority: flush=1 together with stall=1 and bubble=1 -> out_pc=32'h0000_4180, out_bd=0, out_valid=0, out_data=0; perf counters cleared to 0.
- Invalid load: in_valid=0, in_data=64'hFFFF, in_tnew=3, CLEAR_ON_INVALID=1 -> out_data=0, out_tnew=0, out_pc=in_pc; CLEAR_ON_INVALID=0 -> out_data=64'hFFFF, out_tnew=0.
